frame_deframer: RTL and testbench

FRAME_DEFRAMER -- requirements
Module: frame_deframer

---
 rtl/frame_deframer_if.sv | 25 ++
 rtl/frame_deframer.sv | 146 ++++++++++++++
 tb/tb_frame_deframer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_deframer_if.sv
// Byte-in / frame-out bus for the frame deframer.
interface frame_deframer_if #(
   parameter int unsigned FRAME_BYTES = 87
);
   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic                     fout_ready;
   logic [FRAME_BYTES*8-1:0] fout;
   logic                     fout_valid;
   logic                     frame_err;
   logic [2:0]               err_code;
   logic                     busy;

   // Byte source and frame consumer side.
   modport master (
      output rx_data, rx_valid, fout_ready,
      input  fout, fout_valid, frame_err, err_code, busy
   );

   // Deframer side.
   modport slave (
      input  rx_data, rx_valid, fout_ready,
      output fout, fout_valid, frame_err, err_code, busy
   );
endinterface

// File: rtl/frame_deframer.sv
// Byte-stuffed frame deframer: collects FRAME_BYTES payload bytes between
// start/end flags, undoes escaping, and holds the frame until accepted.
module frame_deframer #(
   parameter int unsigned FRAME_BYTES = 87,
   parameter logic [7:0]  FRAME_START = 8'h06,
   parameter logic [7:0]  FRAME_END   = 8'h07,
   parameter logic [7:0]  ESC_VAL     = 8'h14,
   parameter logic [7:0]  ESC_XOR     = 8'h20
) (
   input  logic           clk,
   input  logic           rst_n,
   frame_deframer_if.slave bus
);
   localparam int unsigned CW = $clog2(FRAME_BYTES + 1);

   localparam logic [2:0] ERR_SHORT   = 3'd1;
   localparam logic [2:0] ERR_LONG    = 3'd2;
   localparam logic [2:0] ERR_BAD_ESC = 3'd3;
   localparam logic [2:0] ERR_RESTART = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_ESC, S_HOLD} state_t;

   state_t        state_q;
   state_t        state_nxt;
   logic [CW-1:0] count;

   logic          is_start;
   logic          is_end;
   logic          is_esc;
   logic          cnt_full;

   logic          err_c;
   logic [2:0]    code_c;
   logic          wr_c;
   logic [7:0]    wr_byte_c;
   logic          clr_c;

   assign is_start = (bus.rx_data == FRAME_START);
   assign is_end   = (bus.rx_data == FRAME_END);
   assign is_esc   = (bus.rx_data == ESC_VAL);
   assign cnt_full = (count == CW'(FRAME_BYTES));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state logic; bytes only move the FSM on rx_valid cycles.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         S_IDLE: if (bus.rx_valid && is_start) state_nxt = S_RECV;
         S_RECV: if (bus.rx_valid) begin
            if (is_start)      state_nxt = S_RECV;
            else if (is_end)   state_nxt = cnt_full ? S_HOLD : S_IDLE;
            else if (is_esc)   state_nxt = S_ESC;
            else if (cnt_full) state_nxt = S_IDLE;
            else               state_nxt = S_RECV;
         end
         S_ESC: if (bus.rx_valid) begin
            if (is_start)      state_nxt = S_RECV;
            else if (is_end)   state_nxt = S_IDLE;
            else if (cnt_full) state_nxt = S_IDLE;
            else               state_nxt = S_RECV;
         end
         S_HOLD: if (bus.fout_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Per-byte actions: store, counter clear and error cause.
   // An escaped byte other than START/END (including ESC_VAL) is stored unmasked-by-XOR.
   always_comb begin
      err_c     = 1'b0;
      code_c    = bus.err_code;
      wr_c      = 1'b0;
      wr_byte_c = bus.rx_data;
      clr_c     = 1'b0;
      unique case (state_q)
         S_IDLE: if (bus.rx_valid && is_start) clr_c = 1'b1;
         S_RECV: if (bus.rx_valid) begin
            if (is_start) begin
               err_c  = 1'b1;
               code_c = ERR_RESTART;
               clr_c  = 1'b1;
            end else if (is_end) begin
               if (!cnt_full) begin
                  err_c  = 1'b1;
                  code_c = ERR_SHORT;
               end
            end else if (!is_esc) begin
               if (cnt_full) begin
                  err_c  = 1'b1;
                  code_c = ERR_LONG;
               end else begin
                  wr_c = 1'b1;
               end
            end
         end
         S_ESC: if (bus.rx_valid) begin
            if (is_start || is_end) begin
               err_c  = 1'b1;
               code_c = ERR_BAD_ESC;
               clr_c  = is_start;
            end else if (cnt_full) begin
               err_c  = 1'b1;
               code_c = ERR_LONG;
            end else begin
               wr_c      = 1'b1;
               wr_byte_c = bus.rx_data ^ ESC_XOR;
            end
         end
         S_HOLD: if (bus.rx_valid) begin
            err_c  = 1'b1;
            code_c = ERR_OVERRUN;
         end
         default: ;
      endcase
   end

   // Registered datapath and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count          <= '0;
         bus.fout       <= '0;
         bus.fout_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.err_code   <= 3'd0;
         bus.busy       <= 1'b0;
      end else begin
         bus.frame_err  <= err_c;
         if (err_c) bus.err_code <= code_c;
         bus.fout_valid <= (state_nxt == S_HOLD);
         bus.busy       <= (state_nxt == S_RECV) || (state_nxt == S_ESC);
         if (clr_c)     count <= '0;
         else if (wr_c) count <= count + CW'(1);
         // First received byte lands in the most-significant slot.
         for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
            if (wr_c && (count == CW'(i)))
               bus.fout[(FRAME_BYTES-1-i)*8 +: 8] <= wr_byte_c;
         end
      end
   end
endmodule

// File: tb/tb_frame_deframer.sv
// Scoreboard bench for frame_deframer with FRAME_BYTES=4.
module tb_frame_deframer;
   localparam int unsigned FB  = 4;
   localparam logic [7:0]  STA = 8'h06;
   localparam logic [7:0]  ENDB = 8'h07;
   localparam logic [7:0]  ESC = 8'h14;
   localparam logic [7:0]  XM  = 8'h20;

   typedef struct {
      bit          is_frame;
      logic [31:0] data;
      logic [2:0]  code;
   } exp_t;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   exp_t exp_q[$];

   // Reference model state: byte list collected so far plus simple mode flags.
   bit         m_in = 0;
   bit         m_esc = 0;
   bit         m_hold = 0;
   logic [7:0] m_bytes[$];

   frame_deframer_if #(.FRAME_BYTES(FB)) bus ();

   frame_deframer #(.FRAME_BYTES(FB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_err(input logic [2:0] c);
      exp_t e;
      e.is_frame = 0; e.data = '0; e.code = c;
      exp_q.push_back(e);
   endtask

   task automatic push_frame();
      exp_t e;
      e.is_frame = 1; e.code = '0; e.data = '0;
      foreach (m_bytes[i]) e.data = {e.data[23:0], m_bytes[i]};
      exp_q.push_back(e);
   endtask

   // Behavioural decoding of one clock cycle of input.
   task automatic model_cycle(input bit v, input logic [7:0] b, input bit rdy);
      logic [7:0] d;
      if (m_hold) begin
         if (v) push_err(3'd5);
         if (rdy) m_hold = 0;
         return;
      end
      if (!v) return;
      if (!m_in) begin
         if (b == STA) begin m_in = 1; m_esc = 0; m_bytes.delete(); end
         return;
      end
      if (b == STA) begin
         push_err(m_esc ? 3'd3 : 3'd4);
         m_bytes.delete(); m_esc = 0;
         return;
      end
      if (b == ENDB) begin
         if (m_esc) push_err(3'd3);
         else if (m_bytes.size() == FB) begin push_frame(); m_hold = 1; end
         else push_err(3'd1);
         m_in = 0; m_esc = 0;
         return;
      end
      if (b == ESC && !m_esc) begin m_esc = 1; return; end
      d = m_esc ? (b ^ XM) : b;
      m_esc = 0;
      if (m_bytes.size() == FB) begin push_err(3'd2); m_in = 0; end
      else m_bytes.push_back(d);
   endtask

   task automatic model_reset();
      m_in = 0; m_esc = 0; m_hold = 0;
      m_bytes.delete();
      exp_q.delete();
   endtask

   // One clock: drive inputs, update model, advance to just after the edge.
   task automatic cyc(input bit v, input logic [7:0] b, input bit rdy);
      bus.rx_valid   = v;
      bus.rx_data    = b;
      bus.fout_ready = rdy;
      model_cycle(v, b, rdy);
      @(posedge clk); #1;
   endtask

   task automatic send(input bq_t q, input bit rdy);
      foreach (q[i]) cyc(1'b1, q[i], rdy);
      bus.rx_valid = 1'b0;
   endtask

   // Monitor: pops expectations on frame_err pulses and fout_valid rises.
   initial begin : monitor
      bit          pv;
      bit          pr;
      logic [31:0] pf;
      logic [2:0]  last_code;
      exp_t        e;
      pv = 0; pr = 0; pf = '0; last_code = 3'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outputs", {bus.fout, 3'(bus.fout_valid), bus.frame_err, bus.err_code, bus.busy},
                64'd0);
            pv = 0; last_code = 3'd0;
            continue;
         end
         if (pv) begin
            if (!pr) begin
               chk("hold_valid", bus.fout_valid, 1);
               chk("hold_stable", bus.fout, pf);
            end else begin
               chk("release_valid", bus.fout_valid, 0);
            end
         end
         if (bus.frame_err) begin
            if (exp_q.size() == 0) begin
               chk("spurious_err", bus.err_code, 0);
               if (bus.err_code == 3'd0) chk("spurious_err_pulse", bus.frame_err, 0);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_err", 64'(e.is_frame), 0);
               chk("err_code", bus.err_code, e.code);
               last_code = e.code;
            end
         end else begin
            chk("err_code_hold", bus.err_code, last_code);
         end
         if (bus.fout_valid && !pv) begin
            if (exp_q.size() == 0) begin
               chk("spurious_frame", bus.fout_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_frame", 64'(e.is_frame), 1);
               chk("frame_data", bus.fout, e.data);
            end
         end
         pv = bus.fout_valid;
         pr = bus.fout_ready;
         pf = bus.fout;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bq_t seq;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.fout_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame, held until accepted.
      seq = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h07};
      send(seq, 1'b0);
      chk("basic_valid", bus.fout_valid, 1);
      chk("basic_data", bus.fout, 32'h11223344);
      chk("basic_busy", bus.busy, 0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("basic_released", bus.fout_valid, 0);

      // Escaped bytes.
      seq = '{8'h06, 8'h14, 8'h26, 8'h14, 8'h27, 8'h14, 8'h34, 8'hAA, 8'h07};
      send(seq, 1'b0);
      chk("esc_data", bus.fout, 32'h060714AA);
      chk("esc_noerr", bus.frame_err, 0);
      cyc(1'b0, 8'h00, 1'b1);

      // Short then long.
      seq = '{8'h06, 8'h11, 8'h22, 8'h07};
      send(seq, 1'b0);
      chk("short_pulse", bus.frame_err, 1);
      chk("short_code", bus.err_code, 1);
      chk("short_novalid", bus.fout_valid, 0);
      seq = '{8'h06, 8'h11, 8'h22, 8'h33};
      send(seq, 1'b0);
      chk("recv_busy", bus.busy, 1);
      seq = '{8'h44, 8'h55};
      send(seq, 1'b0);
      chk("long_pulse", bus.frame_err, 1);
      chk("long_code", bus.err_code, 2);
      chk("long_busy", bus.busy, 0);
      cyc(1'b0, 8'h00, 1'b0);
      chk("pulse_single", bus.frame_err, 0);

      // Restart, then bad escape.
      seq = '{8'h06, 8'h11, 8'h06};
      send(seq, 1'b0);
      chk("restart_code", bus.err_code, 4);
      seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h07};
      send(seq, 1'b0);
      chk("restart_data", bus.fout, 32'hA1A2A3A4);
      cyc(1'b0, 8'h00, 1'b1);
      seq = '{8'h06, 8'h14, 8'h07};
      send(seq, 1'b0);
      chk("badesc_code", bus.err_code, 3);
      chk("badesc_idle", bus.busy, 0);

      // Overrun while holding, then accept coinciding with a byte.
      seq = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h07};
      send(seq, 1'b0);
      cyc(1'b1, 8'h06, 1'b0);
      chk("overrun_code", bus.err_code, 5);
      chk("overrun_data", bus.fout, 32'h11223344);
      chk("overrun_valid", bus.fout_valid, 1);
      cyc(1'b1, 8'h55, 1'b1);
      chk("overrun_accept", bus.fout_valid, 0);
      chk("overrun_accept_code", bus.err_code, 5);

      // Reset mid-frame.
      seq = '{8'h06, 8'h11};
      send(seq, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset", {bus.fout, 3'(bus.fout_valid), bus.frame_err, bus.err_code, bus.busy}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      seq = '{8'h06, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h07};
      send(seq, 1'b0);
      chk("post_reset_data", bus.fout, 32'h5A6B7C8D);
      cyc(1'b0, 8'h00, 1'b1);

      // Randomized framed traffic with escaping, gaps, corruption and back-pressure.
      for (int f = 0; f < 400; f++) begin
         bq_t         q;
         int unsigned len;
         logic [7:0]  d;
         q.delete();
         if ($urandom_range(0, 9) == 0) q.push_back(8'($urandom));
         q.push_back(STA);
         len = $urandom_range(0, 4) == 0 ? $urandom_range(2, 6) : FB;
         for (int unsigned k = 0; k < len; k++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) d = 8'($urandom_range(6, 7));
            if ($urandom_range(0, 7) == 0) d = ESC;
            if (d == STA || d == ENDB || d == ESC) begin
               q.push_back(ESC);
               q.push_back(d ^ XM);
            end else begin
               q.push_back(d);
            end
            if ($urandom_range(0, 29) == 0) q.push_back(8'($urandom));
         end
         q.push_back(ENDB);
         foreach (q[i]) begin
            while ($urandom_range(0, 5) == 0) cyc(1'b0, 8'($urandom), $urandom_range(0, 2) == 0);
            cyc(1'b1, q[i], $urandom_range(0, 2) == 0);
         end
      end

      repeat (8) cyc(1'b0, 8'h00, 1'b1);
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
